// File: rtl/shift_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_ctrl_pkg
// Shared definitions for the shift issue controller slice:
//   - default operand width, shift-field width and request FIFO depth
//   - FSM state encoding used by shift_issue_ctrl
//   - request entry layout {a, shift} as stored in the request FIFO
// No ports (package).
// -----------------------------------------------------------------------------
package shift_ctrl_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int SW_DEF    = 3;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Request entry at the default widths. The FIFO stores entries as a flat
    // vector in this same field order ({a, shift}) so any WIDTH/SW works.
    typedef struct packed {
        logic [WIDTH_DEF-1:0] a;
        logic [SW_DEF-1:0]    shift;
    } req_t;

endpackage : shift_ctrl_pkg

// File: rtl/shift_req_fifo.sv
// -----------------------------------------------------------------------------
// shift_req_fifo
// Synchronous request FIFO; DEPTH must be a power of 2 (minimum 2) so the
// read/write pointers wrap naturally modulo DEPTH.
// Ports:
//   CLK      clock
//   RST      asynchronous active-low reset (empties the FIFO)
//   i_push   write i_data (ignored while full)
//   i_pop    drop the head entry (ignored while empty)
//   i_data   entry to write
//   o_data   head entry (valid while !o_empty)
//   o_full   DEPTH entries stored
//   o_empty  no entries stored
//   o_count  occupancy, log2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module shift_req_fifo
    import shift_ctrl_pkg::*;
#(
    parameter int DW    = WIDTH_DEF + SW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [DW-1:0]          i_data,
    output logic [DW-1:0]          o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_do_push = i_push && (r_count != FULL_CNT);
    assign w_do_pop  = i_pop  && (r_count != ZERO_CNT);

    // Storage array write.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DW{1'b0}};
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Write/read pointers, wrapping modulo DEPTH.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy count; simultaneous push and pop leave it unchanged.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_count <= ZERO_CNT;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == ZERO_CNT);
    assign o_count = r_count;

endmodule : shift_req_fifo

// File: rtl/shift_issue_ctrl.sv
// -----------------------------------------------------------------------------
// shift_issue_ctrl
// Upstream sequencer for the multi-cycle variable left shifter. Buffers
// requests in a FIFO, issues each one with a single-cycle start pulse while
// holding operand/width steady, captures the result at a fixed cycle and
// presents it on a valid/ready output.
//
// Build option: define SHIFT_CHECK_EN to add the sticky 'err' output, set when
// the captured shifter result differs from (sh_a << sh_width).
//
// Ports:
//   CLK, RST               clock; asynchronous active-low reset
//   in_valid/in_ready      request handshake; in_a operand, in_shift width
//   sh_start               one-cycle start pulse to the shifter (registered)
//   sh_a, sh_width         operands to the shifter, held for the whole shift
//   sh_result              shifter output
//   out_valid/out_ready    result handshake; out_data result, out_shift width
//   busy                   FSM not idle or FIFO not empty (registered)
//   err                    (SHIFT_CHECK_EN only) sticky result mismatch flag
// -----------------------------------------------------------------------------
module shift_issue_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SW    = SW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SW-1:0]    in_shift,
    output logic             sh_start,
    output logic [WIDTH-1:0] sh_a,
    output logic [SW-1:0]    sh_width,
    input  logic [WIDTH-1:0] sh_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_shift,
    output logic             busy
`ifdef SHIFT_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam int DW   = WIDTH + SW;
    localparam int QCW  = $clog2(DEPTH) + 1;
    localparam int CNTW = SW + 1;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_pop;
    logic             w_push;
    logic             w_capture;
    logic             w_out_hs;
    logic [DW-1:0]    w_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [QCW-1:0]   w_count;
    logic [QCW-1:0]   w_count_nxt;
    logic [CNTW-1:0]  r_cnt;
    logic [CNTW-1:0]  w_cnt_done;

    logic             r_sh_start;
    logic [WIDTH-1:0] r_sh_a;
    logic [SW-1:0]    r_sh_width;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SW-1:0]    r_out_shift;
    logic             r_busy;

    assign in_ready = !w_fifo_full;
    assign w_push   = in_valid && !w_fifo_full;
    assign w_out_hs = r_out_valid && out_ready;

    shift_req_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({in_a, in_shift}),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_count)
    );

    // The shifter's final value is valid to sample at edge w+2 after the
    // start edge; with cnt cleared at edge 0 that is the edge where cnt==w+1.
    // For w=max this lands on edge 2^SW+1, just before the shifter wraps.
    assign w_cnt_done = {1'b0, r_sh_width} + {{SW{1'b0}}, 1'b1};

    // Next-state logic: pops are issued from IDLE and, back-to-back, from OUT.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_START;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_START: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_cnt == w_cnt_done) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_OUT;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (w_out_hs) begin
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = ST_START;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_next_state = ST_OUT;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FIFO occupancy after this edge, used to register busy.
    always_comb begin
        w_count_nxt = w_count;
        if (w_push && !w_pop) begin
            w_count_nxt = w_count + QCW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = w_count - QCW'(1);
        end else begin
            w_count_nxt = w_count;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Shifter drive: a pop always enters START, so the start pulse is the
    // registered pop; operands load only on a pop and are held otherwise.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sh_start <= 1'b0;
            r_sh_a     <= {WIDTH{1'b0}};
            r_sh_width <= {SW{1'b0}};
        end else begin
            r_sh_start <= w_pop;
            if (w_pop) begin
                r_sh_a     <= w_head[DW-1:SW];
                r_sh_width <= w_head[SW-1:0];
            end
        end
    end

    // Cycle counter: zero outside WAIT (START's exit edge clears it).
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= {CNTW{1'b0}};
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt + CNTW'(1);
        end else begin
            r_cnt <= {CNTW{1'b0}};
        end
    end

    // Result capture and output handshake; data is only written at capture
    // so it stays stable while out_ready is low.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {WIDTH{1'b0}};
            r_out_shift <= {SW{1'b0}};
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_data  <= sh_result;
            r_out_shift <= r_sh_width;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    // Busy flag registered from next state and next FIFO occupancy.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_next_state != ST_IDLE) || (w_count_nxt != {QCW{1'b0}});
        end
    end

`ifdef SHIFT_CHECK_EN
    logic [WIDTH-1:0] w_expect;
    logic             r_err;

    assign w_expect = r_sh_a << r_sh_width;

    // Sticky mismatch flag, evaluated only at the capture edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_err <= 1'b0;
        end else if (w_capture && (sh_result != w_expect)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

    assign sh_start  = r_sh_start;
    assign sh_a      = r_sh_a;
    assign sh_width  = r_sh_width;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_shift = r_out_shift;
    assign busy      = r_busy;

endmodule : shift_issue_ctrl

// File: tb/tb_shift_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_issue_ctrl
// Directed + randomized bench for shift_issue_ctrl with a behavioural model of
// the downstream shifter and a request queue as the reference model.
// Define SHIFT_CHECK_EN to also exercise the err output.
// -----------------------------------------------------------------------------
module tb_shift_issue_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'h00;
    logic [2:0] in_shift = 3'd0;
    logic       sh_start;
    logic [7:0] sh_a;
    logic [2:0] sh_width;
    logic [7:0] sh_result;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] out_shift;
    logic       busy;
`ifdef SHIFT_CHECK_EN
    logic       err;
`endif

    shift_issue_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_shift  (in_shift),
        .sh_start  (sh_start),
        .sh_a      (sh_a),
        .sh_width  (sh_width),
        .sh_result (sh_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .busy      (busy)
`ifdef SHIFT_CHECK_EN
        ,
        .err       (err)
`endif
    );

    always #100 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Shifter model: start seen at edge 0, loads sh_a at edge 1, shifts at
    // edges 2..w+1, then its counter wraps at edge 9 and reloads sh_a.
    logic [7:0] s_reg;
    logic [2:0] s_w;
    int         s_k;
    logic       force_zero = 1'b0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s_reg <= 8'h00;
            s_w   <= 3'd0;
            s_k   <= 0;
        end else if (sh_start) begin
            s_k <= 1;
        end else if (s_k == 1 || s_k == 9) begin
            s_reg <= sh_a;
            s_w   <= sh_width;
            s_k   <= 2;
        end else if (s_k != 0) begin
            if (s_k <= int'(s_w) + 1) s_reg <= s_reg << 1;
            s_k <= s_k + 1;
        end
    end

    assign sh_result = force_zero ? 8'h00 : s_reg;

    // Start pulse monitor.
    int   n_starts = 0;
    int   n_double = 0;
    logic prev_start = 1'b0;
    always @(negedge CLK) begin
        if (sh_start) n_starts <= n_starts + 1;
        if (sh_start && prev_start) n_double <= n_double + 1;
        prev_start <= sh_start;
    end

    typedef struct packed {
        logic [7:0] a;
        logic [2:0] w;
    } op_t;
    op_t model_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic push(input logic [7:0] a, input logic [2:0] w, output int hs);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_shift = w;
        while (!in_ready && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
        hs = cyc + 1;
        @(negedge CLK);
        in_valid = 1'b0;
        model_q.push_back('{a: a, w: w});
    endtask

    // Waits for a result, checks it against the model, stalls, consumes it.
    task automatic collect(input int exp_cyc, input bit zero_res, input int stall, input bit b2b);
        op_t        op;
        logic [7:0] ed;
        int         n;
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge CLK);
            n++;
        end
        chk("out_valid_seen", 32'(out_valid), 32'd1);
        op = model_q.pop_front();
        ed = zero_res ? 8'h00 : 8'((int'(op.a) * (1 << int'(op.w))) % 256);
        if (exp_cyc >= 0) chk("latency", 32'(cyc), 32'(exp_cyc));
        chk("out_data", 32'(out_data), 32'(ed));
        chk("out_shift", 32'(out_shift), 32'(op.w));
        for (int i = 0; i < stall; i++) begin
            @(negedge CLK);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(ed));
        end
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        chk("out_valid_clear", 32'(out_valid), 32'd0);
        if (b2b) chk("b2b_start", 32'(sh_start), 32'd1);
    endtask

    int hs;
    int hs6;
    int s0;
    int n_ov;
    logic [7:0] ra;
    logic [2:0] rw;

    initial begin
        // Reset state.
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sh_start", 32'(sh_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_sh_a", 32'({sh_a, sh_width, out_shift}), 32'd0);
`ifdef SHIFT_CHECK_EN
        chk("rst_err", 32'(err), 32'd0);
`endif
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // Single op: 0x03 << 2.
        s0 = n_starts;
        push(8'h03, 3'd2, hs);
        collect(hs + 6, 1'b0, 0, 1'b0);
        chk("idle_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge CLK);
        chk("single_start", 32'(n_starts - s0), 32'd1);

        // Zero shift.
        s0 = n_starts;
        push(8'hA5, 3'd0, hs);
        collect(hs + 4, 1'b0, 0, 1'b0);
        repeat (2) @(negedge CLK);
        chk("zero_start", 32'(n_starts - s0), 32'd1);

        // Maximum shift, capture just before the shifter wraps.
        push(8'h01, 3'd7, hs);
        collect(hs + 11, 1'b0, 0, 1'b0);
        push(8'hFF, 3'd7, hs);
        collect(hs + 11, 1'b0, 2, 1'b0);

        // Backpressure: five accepted (one in flight, four buffered), sixth waits.
        for (int i = 1; i <= 5; i++) push(8'(i), 3'd1, hs);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        fork
            push(8'd6, 3'd1, hs6);
            begin
                for (int i = 1; i <= 6; i++) collect(-1, 1'b0, 0, (i <= 5));
            end
        join
        repeat (2) @(negedge CLK);
        chk("drain_busy", 32'(busy), 32'd0);

        // Randomized single ops with random output stalls.
        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom);
            rw = 3'($urandom_range(0, 7));
            push(ra, rw, hs);
            collect(hs + int'(rw) + 4, 1'b0, int'($urandom_range(0, 3)), 1'b0);
        end

`ifdef SHIFT_CHECK_EN
        // Corrupted shifter result sets the sticky error flag.
        chk("err_clean", 32'(err), 32'd0);
        force_zero = 1'b1;
        push(8'h03, 3'd1, hs);
        collect(hs + 5, 1'b1, 0, 1'b0);
        force_zero = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        push(8'h40, 3'd2, hs);
        collect(hs + 6, 1'b0, 0, 1'b0);
        chk("err_sticky", 32'(err), 32'd1);
`endif

        // Reset in the middle of WAIT discards the in-flight op.
        push(8'h11, 3'd5, hs);
        repeat (4) @(negedge CLK);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        model_q.delete();
        RST = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sh_start", 32'(sh_start), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        n_ov = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (out_valid) n_ov++;
        end
        chk("no_result_after_rst", 32'(n_ov), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Block still works after the abort.
        push(8'h11, 3'd5, hs);
        collect(hs + 9, 1'b0, 0, 1'b0);

        chk("start_pulse_width", 32'(n_double), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_shift_issue_ctrl
